// File: rtl/dmux_pkg.sv
// -----------------------------------------------------------------------------
// dmux_pkg
// Shared constants and helpers for the stream demultiplexer family.
//   DROP_CNT_W : width of the saturating dropped-word counter
//   clog2()    : ceiling log2, usable in parameter/localparam expressions
// -----------------------------------------------------------------------------
package dmux_pkg;

    localparam int DROP_CNT_W = 8;

    // Ceiling log2 of value; clog2(1) = 0, clog2(3) = 2, clog2(4) = 2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dmux_ch_fifo.sv
// -----------------------------------------------------------------------------
// dmux_ch_fifo
// Per-channel show-ahead FIFO. The head word is presented on 'head' with
// 'valid' high as soon as the FIFO is non-empty; no read request is needed.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   push, din  : write request and word; ignored while full
//   pop        : remove the head at the edge; ignored while empty
//   head       : current head word (meaningful only while valid)
//   valid      : FIFO non-empty
//   full       : registered, FIFO holds DEPTH entries after the edge
// -----------------------------------------------------------------------------
module dmux_ch_fifo
    import dmux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full
);

    localparam int AW = clog2(DEPTH);

    // Storage is not reset: the pointers alone define which entries are live.
    logic [DATA_W-1:0] mem [DEPTH];

    // One extra pointer bit distinguishes full from empty when the index bits match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_nxt;
    logic [AW:0] rd_nxt;
    logic        empty;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign valid   = !empty;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign wr_nxt = do_push ? (wr_ptr + (AW+1)'(1)) : wr_ptr;
    assign rd_nxt = do_pop  ? (rd_ptr + (AW+1)'(1)) : rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            // Full is evaluated on the post-edge pointers so it tracks occupancy
            // after a simultaneous push/pop as well.
            full   <= (wr_nxt[AW] != rd_nxt[AW]) &&
                      (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dmux_nch_buf.sv
// -----------------------------------------------------------------------------
// dmux_nch_buf
// Single-clock 1-to-N stream demultiplexer with a DEPTH-entry FIFO per output
// channel. Each accepted word goes to data_in_ch, or to every channel when
// data_in_bcast is set. Unicasts to a non-existent channel are accepted and
// dropped, and counted in drop_cnt (saturating).
// Ports:
//   clk_a, rst_n    : clock (rising edge), asynchronous active-low reset
//   data_in         : input word
//   data_in_valid   : input word present
//   data_in_ch      : destination channel index
//   data_in_bcast   : write to all channels (data_in_ch ignored)
//   data_in_ready   : input accepted this cycle if valid
//   data_out        : lane k = FIFO head of channel k, zero when not valid
//   data_out_valid  : per-channel head valid
//   data_out_ready  : per-channel consumer takes its head
//   ch_full         : per-channel FIFO full (registered)
//   drop_cnt        : saturating count of words dropped for a bad index
// -----------------------------------------------------------------------------
module dmux_nch_buf
    import dmux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_CH   = 4,
    parameter  int DEPTH  = 4,
    localparam int CH_W   = clog2(N_CH)
) (
    input  logic                   clk_a,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   data_in_valid,
    input  logic [CH_W-1:0]        data_in_ch,
    input  logic                   data_in_bcast,
    output logic                   data_in_ready,
    output logic [N_CH*DATA_W-1:0] data_out,
    output logic [N_CH-1:0]        data_out_valid,
    input  logic [N_CH-1:0]        data_out_ready,
    output logic [N_CH-1:0]        ch_full,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    logic [N_CH-1:0]   full;
    logic [N_CH-1:0]   valid;
    logic [N_CH-1:0]   push_ch;
    logic [DATA_W-1:0] head [N_CH];

    logic ch_ok;
    logic sel_full;
    logic accept;
    logic drop;

    // Index widths are rounded up to a power of two, so with a non power-of-two
    // channel count some index values name no channel.
    assign ch_ok = (int'(data_in_ch) < N_CH);

    // Explicit decode avoids indexing past the last channel.
    always_comb begin
        sel_full = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (data_in_ch == CH_W'(k)) begin
                sel_full = full[k];
            end
        end
    end

    // Ready depends only on registered full flags, never on the consumers'
    // same-cycle ready, so a full channel refuses input even while popping.
    // Broadcasts are all-or-nothing.
    always_comb begin
        if (data_in_bcast) begin
            data_in_ready = ~|full;
        end else if (ch_ok) begin
            data_in_ready = !sel_full;
        end else begin
            data_in_ready = 1'b1;
        end
    end

    assign accept = data_in_valid && data_in_ready;
    assign drop   = accept && !data_in_bcast && !ch_ok;

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_ch
            assign push_ch[k] = accept &&
                                (data_in_bcast || (ch_ok && (data_in_ch == CH_W'(k))));

            dmux_ch_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk   (clk_a),
                .rst_n (rst_n),
                .push  (push_ch[k]),
                .pop   (data_out_ready[k]),
                .din   (data_in),
                .head  (head[k]),
                .valid (valid[k]),
                .full  (full[k])
            );

            // Lanes without a valid head read as zero rather than stale storage.
            assign data_out[k*DATA_W +: DATA_W] = valid[k] ? head[k] : '0;
        end
    endgenerate

    assign data_out_valid = valid;
    assign ch_full        = full;

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmux_nch_buf.sv
// -----------------------------------------------------------------------------
// tb_dmux_nch_buf
// Drives a 4-channel and a 3-channel instance of dmux_nch_buf and compares
// them against per-channel word queues and a saturating drop counter.
// -----------------------------------------------------------------------------
module tb_dmux_nch_buf;

    localparam int DEPTH = 4;

    logic        clk_a;
    logic        rst_n;

    logic [7:0]  din4, din3;
    logic        v4, v3;
    logic [1:0]  ch4, ch3;
    logic        b4, b3;
    logic        rdy4, rdy3;
    logic [31:0] dout4;
    logic [23:0] dout3;
    logic [3:0]  vld4, ordy4, full4;
    logic [2:0]  vld3, ordy3, full3;
    logic [7:0]  drop4, drop3;

    int n_checks;
    int n_fail;

    // Reference state: queues 0..3 model the 4-channel instance, 4..6 the
    // 3-channel instance. dcnt[0]/dcnt[1] are the expected drop counts.
    logic [7:0] mq [8][$];
    int         dcnt [2];
    logic       last_rdy;

    dmux_nch_buf #(.DATA_W(8), .N_CH(4), .DEPTH(DEPTH)) u_dut4 (
        .clk_a          (clk_a),
        .rst_n          (rst_n),
        .data_in        (din4),
        .data_in_valid  (v4),
        .data_in_ch     (ch4),
        .data_in_bcast  (b4),
        .data_in_ready  (rdy4),
        .data_out       (dout4),
        .data_out_valid (vld4),
        .data_out_ready (ordy4),
        .ch_full        (full4),
        .drop_cnt       (drop4)
    );

    dmux_nch_buf #(.DATA_W(8), .N_CH(3), .DEPTH(DEPTH)) u_dut3 (
        .clk_a          (clk_a),
        .rst_n          (rst_n),
        .data_in        (din3),
        .data_in_valid  (v3),
        .data_in_ch     (ch3),
        .data_in_bcast  (b3),
        .data_in_ready  (rdy3),
        .data_out       (dout3),
        .data_out_valid (vld3),
        .data_out_ready (ordy3),
        .ch_full        (full3),
        .drop_cnt       (drop3)
    );

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mq[i].delete();
        dcnt[0] = 0;
        dcnt[1] = 0;
    endtask

    task automatic check_outs(input int nch);
        int          base;
        int          u;
        logic [31:0] ed, od;
        logic [3:0]  ev, ef, ov, of_;
        logic [7:0]  odc;
        base = (nch == 4) ? 0 : 4;
        u    = (nch == 4) ? 0 : 1;
        ed = '0; ev = '0; ef = '0;
        for (int k = 0; k < nch; k++) begin
            if (mq[base+k].size() > 0) begin
                ev[k] = 1'b1;
                ed[k*8 +: 8] = mq[base+k][0];
            end
            if (mq[base+k].size() == DEPTH) ef[k] = 1'b1;
        end
        if (nch == 4) begin
            od = dout4; ov = vld4; of_ = full4; odc = drop4;
        end else begin
            od = {8'h00, dout3}; ov = {1'b0, vld3}; of_ = {1'b0, full3}; odc = drop3;
        end
        check("data_out", od, ed);
        check("data_out_valid", {28'b0, ov}, {28'b0, ev});
        check("ch_full", {28'b0, of_}, {28'b0, ef});
        check("drop_cnt", {24'b0, odc}, 32'(dcnt[u]));
    endtask

    // One clock of stimulus on the selected instance, with model update and
    // comparison of ready (before the edge) and all outputs (after the edge).
    task automatic cyc(input int nch, input logic v, input logic [1:0] ch, input logic b,
                       input logic [7:0] d, input logic [3:0] ordy);
        int   base;
        int   u;
        logic er;
        logic allroom;
        base = (nch == 4) ? 0 : 4;
        u    = (nch == 4) ? 0 : 1;
        if (nch == 4) begin
            v4 = v; ch4 = ch; b4 = b; din4 = d; ordy4 = ordy;
            v3 = 1'b0; ordy3 = '0;
        end else begin
            v3 = v; ch3 = ch; b3 = b; din3 = d; ordy3 = ordy[2:0];
            v4 = 1'b0; ordy4 = '0;
        end
        #1;
        allroom = 1'b1;
        for (int k = 0; k < nch; k++) if (mq[base+k].size() >= DEPTH) allroom = 1'b0;
        if (b)                   er = allroom;
        else if (int'(ch) < nch) er = (mq[base+int'(ch)].size() < DEPTH);
        else                     er = 1'b1;
        last_rdy = (nch == 4) ? rdy4 : rdy3;
        check("data_in_ready", {31'b0, last_rdy}, {31'b0, er});
        @(posedge clk_a);
        for (int k = 0; k < nch; k++) begin
            if (ordy[k] && mq[base+k].size() > 0) void'(mq[base+k].pop_front());
        end
        if (v && er) begin
            if (b) begin
                for (int k = 0; k < nch; k++) mq[base+k].push_back(d);
            end else if (int'(ch) < nch) begin
                mq[base+int'(ch)].push_back(d);
            end else if (dcnt[u] < 255) begin
                dcnt[u]++;
            end
        end
        #1;
        check_outs(nch);
    endtask

    logic [7:0] words [5];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        v4 = 0; ch4 = 0; b4 = 0; din4 = 0; ordy4 = 0;
        v3 = 0; ch3 = 0; b3 = 0; din3 = 0; ordy3 = 0;
        model_clear();
        repeat (3) @(posedge clk_a);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_valid4", {28'b0, vld4}, 32'h0);
        check("rst_dout4", dout4, 32'h0);
        check("rst_ready4_idle", {31'b0, rdy4}, 32'h1);
        check_outs(4);
        check_outs(3);

        // Unicast to channel 2.
        cyc(4, 1, 2'd2, 0, 8'd54, 4'h0);
        check("t1_valid", {28'b0, vld4}, 32'h4);
        check("t1_dout", dout4, 32'h0036_0000);
        cyc(4, 0, 0, 0, 0, 4'hf);

        // Channel 1 stalled: four accepted, fifth refused, then ordered drain.
        words[0] = 8'h11; words[1] = 8'h12; words[2] = 8'h13; words[3] = 8'h14; words[4] = 8'h15;
        for (int i = 0; i < 5; i++) begin
            cyc(4, 1, 2'd1, 0, words[i], 4'h0);
            if (i == 3) check("t2_full", {28'b0, full4}, 32'h2);
        end
        check("t2_fifth_refused", {31'b0, last_rdy}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("t2_order", {24'b0, dout4[15:8]}, {24'b0, words[i]});
            cyc(4, 0, 0, 0, 0, 4'b0010);
        end
        check("t2_drained", {28'b0, vld4}, 32'h0);

        // Broadcast into empty channels, then blocked by a full channel 3.
        cyc(4, 1, 2'd0, 1, 8'd45, 4'h0);
        check("t3_bcast", dout4, 32'h2d2d_2d2d);
        cyc(4, 0, 0, 0, 0, 4'hf);
        for (int i = 0; i < 4; i++) cyc(4, 1, 2'd3, 0, 8'(8'hA0 + i), 4'h0);
        cyc(4, 1, 2'd0, 1, 8'h99, 4'h0);
        check("t3_bcast_blocked", {31'b0, last_rdy}, 32'h0);
        check("t3_no_partial", {28'b0, vld4}, 32'h8);
        for (int i = 0; i < 4; i++) cyc(4, 0, 0, 0, 0, 4'b1000);

        // Full channel 0 refuses even while popping; half-full push+pop keeps occupancy.
        for (int i = 0; i < 4; i++) cyc(4, 1, 2'd0, 0, 8'(8'h60 + i), 4'h0);
        cyc(4, 1, 2'd0, 0, 8'h77, 4'h1);
        check("t5_full_refused", {31'b0, last_rdy}, 32'h0);
        cyc(4, 0, 0, 0, 0, 4'h1);
        cyc(4, 1, 2'd0, 0, 8'h88, 4'h1);
        check("t5_pushpop_ready", {31'b0, last_rdy}, 32'h1);
        check("t5_not_full", {28'b0, full4}, 32'h0);
        for (int i = 0; i < 3; i++) cyc(4, 0, 0, 0, 0, 4'h1);

        // Invalid channel index on the 3-channel instance.
        for (int i = 0; i < 300; i++) cyc(3, 1, 2'd3, 0, 8'($urandom), 3'b111);
        check("t4_drop_sat", {24'b0, drop3}, 32'd255);
        check("t4_no_output", {29'b0, vld3}, 32'h0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            cyc(3, ($urandom_range(3) != 0), 2'($urandom), ($urandom_range(7) == 0),
                8'($urandom), 4'($urandom & $urandom));
        end
        for (int i = 0; i < 1500; i++) begin
            cyc(4, ($urandom_range(3) != 0), 2'($urandom), ($urandom_range(7) == 0),
                8'($urandom), 4'($urandom | $urandom));
        end

        // Asynchronous reset while three channels hold data.
        for (int i = 0; i < 6; i++) cyc(4, 0, 0, 0, 0, 4'hf);
        for (int i = 0; i < 6; i++) cyc(4, 1, 2'(i % 3), 0, 8'(8'hC0 + i), 4'h0);
        cyc(3, 1, 2'd3, 0, 8'h00, 3'b000);
        check("t6_pre_valid", {28'b0, vld4}, 32'h7);
        v4 = 1'b0; v3 = 1'b0;
        rst_n = 1'b0;
        #2;
        check("t6_valid4", {28'b0, vld4}, 32'h0);
        check("t6_dout4", dout4, 32'h0);
        check("t6_full4", {28'b0, full4}, 32'h0);
        check("t6_drop3", {24'b0, drop3}, 32'h0);
        check("t6_valid3", {29'b0, vld3}, 32'h0);
        model_clear();
        @(posedge clk_a);
        #1;
        rst_n = 1'b1;
        cyc(4, 1, 2'd3, 0, 8'h5A, 4'h0);
        cyc(4, 0, 0, 0, 0, 4'hf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
